// File: rtl/fft64_pkg.sv
// fft64_pkg: shared FFT-64 constants, twiddle index type, sequencer state enum
// and the sample-index to twiddle-control mapping.
package fft64_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;

  typedef logic [FFT_LOG2N-1:0] tw_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic    rot;
    tw_idx_t idx;
  } tw_ctrl_t;

  // Group size is 64>>stage; the upper half of each group rotates. Because the
  // group size is a power of two, k >= H reduces to one bit of n, and the
  // 6-bit truncation of the shift supplies the mod 64.
  function automatic tw_ctrl_t tw_map(input tw_idx_t n, input int stage, input logic inv);
    tw_ctrl_t r;
    tw_idx_t  half;
    half  = tw_idx_t'((FFT_N / 2) >> stage);
    r.rot = |(n & half);
    r.idx = r.rot ? tw_idx_t'((n & (half - tw_idx_t'(1))) << stage) : '0;
    if (inv) begin
      r.idx = tw_idx_t'(0) - r.idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft64_tm_ctrl_if.sv
// fft64_tm_ctrl_if: butterfly-side sample markers in, twiddle-multiplier controls out.
// The `inverse` signal exists only when FFT_TM_CTRL_IFFT_EN is defined.
interface fft64_tm_ctrl_if;
  import fft64_pkg::*;

  logic    din_valid;
  logic    din_sop;
`ifdef FFT_TM_CTRL_IFFT_EN
  logic    inverse;
`endif
  logic    halt_ctrl;
  tw_idx_t tm64_ctrl;
  logic    dout_valid;
  logic    dout_sop;
  logic    frame_err;

`ifdef FFT_TM_CTRL_IFFT_EN
  modport master (
    output din_valid, din_sop, inverse,
    input  halt_ctrl, tm64_ctrl, dout_valid, dout_sop, frame_err
  );
  modport slave (
    input  din_valid, din_sop, inverse,
    output halt_ctrl, tm64_ctrl, dout_valid, dout_sop, frame_err
  );
`else
  modport master (
    output din_valid, din_sop,
    input  halt_ctrl, tm64_ctrl, dout_valid, dout_sop, frame_err
  );
  modport slave (
    input  din_valid, din_sop,
    output halt_ctrl, tm64_ctrl, dout_valid, dout_sop, frame_err
  );
`endif

endinterface

// File: rtl/fft_valid_delay.sv
// fft_valid_delay: DEPTH-stage shift register carrying {valid, sop} markers,
// cleared asynchronously so no stale marker survives a reset.
module fft_valid_delay
  import fft64_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic sop_in,
  output logic valid_out,
  output logic sop_out
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] sop_q, sop_d;

  always_comb begin
    valid_d    = valid_q;
    sop_d      = sop_q;
    valid_d[0] = valid_in;
    sop_d[0]   = sop_in;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      sop_d[i]   = sop_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sop_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign sop_out   = sop_q[DEPTH-1];

endmodule

// File: rtl/fft64_tm_ctrl.sv
// fft64_tm_ctrl: per-sample rotate/bypass and twiddle index for one DIF stage,
// plus {valid, sop} markers aligned to the multiplier output. FFT_TM_CTRL_IFFT_EN adds `inverse`.
//
// state   | meaning
// ST_IDLE | waiting for a valid sop; valid without sop is dropped and flagged
// ST_RUN  | inside a frame; each valid advances n, n=63 returns to ST_IDLE
module fft64_tm_ctrl
  import fft64_pkg::*;
#(
  parameter int STAGE      = 0,
  parameter int TM_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  fft64_tm_ctrl_if.slave  tm_if
);

  fsm_state_t state_q, state_d;
  tw_idx_t    n_q, n_d;
  logic       halt_q, halt_d;
  tw_idx_t    tm_q, tm_d;
  logic       err_q, err_d;
  logic       accept;
  logic       sop_acc;
  tw_idx_t    cur_n;
  logic       inv_cur;
  tw_ctrl_t   ctrl;
  logic       dly_valid;
  logic       dly_sop;
`ifdef FFT_TM_CTRL_IFFT_EN
  logic       inv_q, inv_d;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    halt_d  = halt_q;
    tm_d    = tm_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    sop_acc = 1'b0;
    cur_n   = n_q;
`ifdef FFT_TM_CTRL_IFFT_EN
    inv_d   = inv_q;
    inv_cur = inv_q;
`else
    inv_cur = 1'b0;
`endif
    if (tm_if.din_valid) begin
      if (tm_if.din_sop) begin
        // An early sop still starts a new frame; it is only flagged.
        accept  = 1'b1;
        sop_acc = 1'b1;
        cur_n   = '0;
        err_d   = (state_q == ST_RUN);
`ifdef FFT_TM_CTRL_IFFT_EN
        inv_cur = tm_if.inverse;
        inv_d   = tm_if.inverse;
`endif
      end else if (state_q == ST_RUN) begin
        accept = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    ctrl = tw_map(cur_n, STAGE, inv_cur);
    if (accept) begin
      halt_d  = ctrl.rot;
      tm_d    = ctrl.idx;
      n_d     = cur_n + tw_idx_t'(1);
      state_d = (cur_n == tw_idx_t'(FFT_N - 1)) ? ST_IDLE : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      halt_q  <= 1'b0;
      tm_q    <= '0;
      err_q   <= 1'b0;
`ifdef FFT_TM_CTRL_IFFT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      halt_q  <= halt_d;
      tm_q    <= tm_d;
      err_q   <= err_d;
`ifdef FFT_TM_CTRL_IFFT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // One stage for the control register plus the multiplier pipeline.
  fft_valid_delay #(
    .DEPTH (1 + TM_LATENCY)
  ) u_valid_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (accept),
    .sop_in    (sop_acc),
    .valid_out (dly_valid),
    .sop_out   (dly_sop)
  );

  assign tm_if.halt_ctrl  = halt_q;
  assign tm_if.tm64_ctrl  = tm_q;
  assign tm_if.frame_err  = err_q;
  assign tm_if.dout_valid = dly_valid;
  assign tm_if.dout_sop   = dly_sop;

endmodule

// File: tb/tb_fft64_tm_ctrl.sv
// tb_fft64_tm_ctrl: drives three instances (STAGE 0, 1, 5) with a shared stream
// and compares them against an arithmetic frame model kept in the bench.
module tb_fft64_tm_ctrl;
  import fft64_pkg::*;

  localparam int LAT = 3;
  localparam int DLY = 1 + LAT;
`ifdef FFT_TM_CTRL_IFFT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic d_valid = 1'b0;
  logic d_sop = 1'b0;

  fft64_tm_ctrl_if if0 ();
  fft64_tm_ctrl_if if1 ();
  fft64_tm_ctrl_if if5 ();

  assign if0.din_valid = d_valid;
  assign if0.din_sop   = d_sop;
  assign if1.din_valid = d_valid;
  assign if1.din_sop   = d_sop;
  assign if5.din_valid = d_valid;
  assign if5.din_sop   = d_sop;
`ifdef FFT_TM_CTRL_IFFT_EN
  logic d_inv = 1'b0;
  assign if0.inverse = d_inv;
  assign if1.inverse = d_inv;
  assign if5.inverse = d_inv;
`endif

  fft64_tm_ctrl #(.STAGE(0), .TM_LATENCY(LAT)) dut0 (.clk(clk), .rst_n(rst_n), .tm_if(if0.slave));
  fft64_tm_ctrl #(.STAGE(1), .TM_LATENCY(LAT)) dut1 (.clk(clk), .rst_n(rst_n), .tm_if(if1.slave));
  fft64_tm_ctrl #(.STAGE(5), .TM_LATENCY(LAT)) dut5 (.clk(clk), .rst_n(rst_n), .tm_if(if5.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       stg[3] = '{0, 1, 5};
  bit       m_run = 1'b0;
  int       m_n = 0;
  bit       m_inv = 1'b0;
  bit       m_err = 1'b0;
  bit [6:0] m_ctrl[3] = '{7'd0, 7'd0, 7'd0};
  bit       hv[0:8191];
  bit       hs[0:8191];
  int       cyc = 0;
  int       rst_edge = 0;

  function automatic bit [6:0] ref_tw(input int n, input int stage, input bit inv);
    int g, h, k, idx;
    g = 64 >> stage;
    h = g / 2;
    k = n % g;
    if (k < h) return 7'd0;
    idx = ((k - h) * (1 << stage)) % 64;
    if (inv) idx = (64 - idx) % 64;
    return {1'b1, idx[5:0]};
  endfunction

  function automatic logic [29:0] exp_vec();
    logic [29:0] r;
    bit dv, ds;
    int idx;
    idx = cyc - DLY;
    dv = (idx >= rst_edge && idx >= 0) ? hv[idx] : 1'b0;
    ds = (idx >= rst_edge && idx >= 0) ? hs[idx] : 1'b0;
    r = '0;
    for (int i = 0; i < 3; i++) r = {r[19:0], m_ctrl[i], dv, ds, m_err};
    return r;
  endfunction

  function automatic logic [29:0] act_vec();
    return {if0.halt_ctrl, if0.tm64_ctrl, if0.dout_valid, if0.dout_sop, if0.frame_err,
            if1.halt_ctrl, if1.tm64_ctrl, if1.dout_valid, if1.dout_sop, if1.frame_err,
            if5.halt_ctrl, if5.tm64_ctrl, if5.dout_valid, if5.dout_sop, if5.frame_err};
  endfunction

  // Drive one cycle, advance the model across the edge, then settle for sampling.
  task automatic step(input bit v, input bit s, input bit inv);
    bit acc;
    int n;
    @(negedge clk);
    d_valid = v;
    d_sop   = s;
`ifdef FFT_TM_CTRL_IFFT_EN
    d_inv   = inv;
`endif
    @(posedge clk);
    acc   = v && (m_run || s);
    m_err = v && ((!m_run && !s) || (m_run && s));
    if (acc) begin
      n = s ? 0 : m_n;
      if (s) m_inv = inv;
      for (int i = 0; i < 3; i++) m_ctrl[i] = ref_tw(n, stg[i], m_inv && INV_EN);
      m_n   = n + 1;
      m_run = (n != 63);
    end
    hv[cyc] = acc;
    hs[cyc] = acc && s;
    cyc++;
    #1;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", act_vec(), 30'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, ($urandom_range(0, 1) == 1), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_frame();
    int sop_seen;
    sop_seen = -1;
    for (int n = 0; n < 64; n++) begin
      step(1'b1, (n == 0), 1'b0);
      if (sop_seen < 0 && if0.dout_sop === 1'b1) sop_seen = n + 1;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame_vec n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
      checks++;
      if ({if5.halt_ctrl, if5.tm64_ctrl} !== ((n % 2 == 1) ? 7'h40 : 7'h00)) begin
        errors++;
        $display("FAIL stage5_n%0d: got %h expected %h", n, {if5.halt_ctrl, if5.tm64_ctrl},
                 ((n % 2 == 1) ? 7'h40 : 7'h00));
      end
      if (n == 27) begin
        checks++;
        if ({if0.halt_ctrl, if0.tm64_ctrl} !== {1'b0, 6'd0}) begin
          errors++;
          $display("FAIL stage0_n27: got %h expected %h", {if0.halt_ctrl, if0.tm64_ctrl}, 7'h00);
        end
        checks++;
        if ({if1.halt_ctrl, if1.tm64_ctrl} !== {1'b1, 6'd22}) begin
          errors++;
          $display("FAIL stage1_n27: got %h expected %h", {if1.halt_ctrl, if1.tm64_ctrl}, {1'b1, 6'd22});
        end
      end
      if (n == 55) begin
        checks++;
        if ({if0.halt_ctrl, if0.tm64_ctrl} !== {1'b1, 6'd23}) begin
          errors++;
          $display("FAIL stage0_n55: got %h expected %h", {if0.halt_ctrl, if0.tm64_ctrl}, {1'b1, 6'd23});
        end
      end
      if (n == 59) begin
        checks++;
        if ({if0.halt_ctrl, if0.tm64_ctrl} !== {1'b1, 6'd27}) begin
          errors++;
          $display("FAIL stage0_n59: got %h expected %h", {if0.halt_ctrl, if0.tm64_ctrl}, {1'b1, 6'd27});
        end
      end
    end
    checks++;
    if (sop_seen !== 4) begin
      errors++;
      $display("FAIL dout_sop_delay: got %0d expected %0d", sop_seen, 4);
    end
    for (int i = 0; i < DLY + 1; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame_drain: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gaps();
    int dv_cnt;
    for (int f = 0; f < 2; f++) begin
      dv_cnt = 0;
      for (int n = 0; n < 64; n++) begin
        if (n > 0 && $urandom_range(0, 2) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            step(1'b0, ($urandom_range(0, 1) == 1), 1'b0);
            dv_cnt += int'(if0.dout_valid);
            checks++;
            if (act_vec() !== exp_vec()) begin
              errors++;
              $display("FAIL gap_hold n=%0d: got %h expected %h", n, act_vec(), exp_vec());
            end
          end
        end
        step(1'b1, (n == 0), 1'b0);
        dv_cnt += int'(if0.dout_valid);
        checks++;
        if ({if0.halt_ctrl, if0.tm64_ctrl, if1.halt_ctrl, if1.tm64_ctrl, if5.halt_ctrl, if5.tm64_ctrl}
            !== {ref_tw(n, 0, 1'b0), ref_tw(n, 1, 1'b0), ref_tw(n, 5, 1'b0)}) begin
          errors++;
          $display("FAIL gap_seq n=%0d: got %h expected %h", n,
                   {if0.halt_ctrl, if0.tm64_ctrl, if1.halt_ctrl, if1.tm64_ctrl, if5.halt_ctrl, if5.tm64_ctrl},
                   {ref_tw(n, 0, 1'b0), ref_tw(n, 1, 1'b0), ref_tw(n, 5, 1'b0)});
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL gap_vec n=%0d: got %h expected %h", n, act_vec(), exp_vec());
        end
      end
      for (int i = 0; i < DLY + 1; i++) begin
        step(1'b0, 1'b0, 1'b0);
        dv_cnt += int'(if0.dout_valid);
      end
      checks++;
      if (dv_cnt !== 64) begin
        errors++;
        $display("FAIL gap_dout_count: got %0d expected %0d", dv_cnt, 64);
      end
    end
  endtask

  task automatic test_drop();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (if0.frame_err !== 1'b1 || act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL drop_err: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < DLY + 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (if0.dout_valid !== 1'b0 || if0.frame_err !== 1'b0 || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_no_marker: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_early_sop();
    for (int n = 0; n < 40; n++) step(1'b1, (n == 0), 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({if0.frame_err, if0.halt_ctrl, if0.tm64_ctrl} !== {1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL early_sop: got %h expected %h", {if0.frame_err, if0.halt_ctrl, if0.tm64_ctrl}, 8'h80);
    end
    for (int n = 1; n < 64; n++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL early_restart n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    idle_steps(DLY + 1);
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n <= 30; n++) step(1'b1, (n == 0), 1'b0);
    @(negedge clk);
    rst_n   = 1'b0;
    d_valid = 1'b0;
    d_sop   = 1'b0;
    m_run = 1'b0; m_n = 0; m_inv = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_ctrl[i] = 7'd0;
    rst_edge = cyc;
    #1;
    checks++;
    if (act_vec() !== 30'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", act_vec(), 30'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (act_vec() !== 30'd0) begin
        errors++;
        $display("FAIL reset_mid_hold: got %h expected %h", act_vec(), 30'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DLY + 2; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (if0.dout_valid !== 1'b0 || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_stale: got %h expected %h", act_vec(), exp_vec());
      end
    end
    for (int n = 0; n < 64; n++) begin
      step(1'b1, (n == 0), 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_frame n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    idle_steps(DLY + 1);
  endtask

  task automatic test_back_to_back();
    bit inv;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 64; n++) begin
        inv = ($urandom_range(0, 1) == 1);
        step(1'b1, (n == 0), inv);
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL b2b f=%0d n=%0d: got %h expected %h", f, n, act_vec(), exp_vec());
        end
      end
    end
    for (int i = 0; i < DLY + 1; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_drain: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

`ifdef FFT_TM_CTRL_IFFT_EN
  task automatic test_inverse();
    for (int n = 0; n < 64; n++) begin
      step(1'b1, (n == 0), (n == 0) ? 1'b1 : ($urandom_range(0, 1) == 1));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL inverse_vec n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
      if (n == 59 || n == 32) begin
        checks++;
        if ({if0.halt_ctrl, if0.tm64_ctrl} !== ((n == 59) ? {1'b1, 6'd37} : {1'b1, 6'd0})) begin
          errors++;
          $display("FAIL inverse_n%0d: got %h expected %h", n, {if0.halt_ctrl, if0.tm64_ctrl},
                   ((n == 59) ? {1'b1, 6'd37} : {1'b1, 6'd0}));
        end
      end
    end
    idle_steps(DLY + 1);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_drop();
    test_early_sop();
    test_reset_mid();
    test_back_to_back();
`ifdef FFT_TM_CTRL_IFFT_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft64_tm_ctrl.md
# fft64_tm_ctrl

Control sequencer that drives the twiddle-multiplier control interface (`halt_ctrl`, `tm64_ctrl`) of the 64-point radix-2 DIF FFT stage. It sits beside the datapath between a butterfly and its twiddle multiplier. It counts samples of each 64-sample frame and issues, per sample, the rotate/bypass decision and the 6-bit twiddle index for its configured stage. It also delays the frame `valid`/`sop` markers so they align with the multiplier output.

## Interface
- `STAGE`, default 0: FFT stage served, 0..5.
- `TM_LATENCY`, default 3: pipeline depth of the twiddle multiplier, from control inputs to data out; 1..8.
- `clk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `din_valid`  in  1: butterfly output sample valid this cycle.
- `din_sop`  in  1: first sample of a frame; qualified by `din_valid`.
- `halt_ctrl`  out  1: 1 = rotate sample by W^tm64_ctrl; 0 = bypass (no rotation).
- `tm64_ctrl`  out  6: twiddle exponent k of W64^k.
- `dout_valid`  out  1: multiplier output valid, aligned to its data.
- `dout_sop`  out  1: first output sample of a frame.
- `frame_err`  out  1: one-cycle pulse on a frame protocol violation.

## Operation
- State machine has two states.
  - IDLE: waits for `din_valid & din_sop`. That sample is index n=0 and the state moves to RUN.
  - RUN: each `din_valid` advances n. After the sample with n=63 is accepted, the state returns to IDLE.
- Per accepted sample n (6-bit), with G = 64>>STAGE and H = G/2:
  - k = n mod G.
  - If k ≥ H: `halt_ctrl`=1 and `tm64_ctrl` = ((k−H) << STAGE) mod 64.
  - Otherwise: `halt_ctrl`=0 and `tm64_ctrl`=0.
- Gaps: while `din_valid`=0, the counter holds and `halt_ctrl`/`tm64_ctrl` hold their last values.
- `din_valid` without `din_sop` in IDLE: the sample is dropped, no control is issued, no dout marker is produced, and `frame_err` pulses.
- `din_valid & din_sop` in RUN (early sop): `frame_err` pulses. The sample is taken as n=0 of a new frame and the state stays RUN.
- `din_sop` without `din_valid` is ignored.

## Timing
- Reset values: state IDLE, n=0, `halt_ctrl`=0, `tm64_ctrl`=0, `dout_valid`=0, `dout_sop`=0, `frame_err`=0. The delay line is cleared.
- `halt_ctrl`/`tm64_ctrl` are registered. They update on the edge that accepts the sample and are valid the cycle after `din_valid`, together with the registered butterfly data.
- `dout_valid`/`dout_sop` equal the accepted `din_valid`/`din_sop` delayed by 1+TM_LATENCY cycles. Dropped samples produce no marker.
- `frame_err` is registered and asserts one cycle after the offending input.
- Back-to-back frames are allowed: sop on the cycle after n=63 is accepted from IDLE with no bubble.
- `rst_n` asserted mid-frame forces the reset values immediately, including flushing in-flight markers. After release, the block waits for a new sop.

## Configuration
- Macro `FFT_TM_CTRL_IFFT_EN`.
- Defined:
  - An extra input port `inverse` (1 bit) is present and sampled at each accepted sop; the value holds for the whole frame.
  - When the held value is 1, the rotating index becomes (64 − idx) mod 64 (conjugate twiddle). `halt_ctrl` is unchanged.
- Undefined: the port is absent and only forward twiddles are produced.

## Structure
- Shared package `fft64_pkg` holds:
  - `FFT_N`=64 and `FFT_LOG2N`=6.
  - `tw_idx_t` (6-bit twiddle index type).
  - The IDLE/RUN state enum.
- Sub-module `fft_valid_delay`: parameterised-depth shift register for `{valid, sop}` with async reset clear. It is instantiated once with depth 1+TM_LATENCY.

## Test plan
- STAGE=0, sop then 64 consecutive valids:
  - n=27 → `halt_ctrl`=0, `tm64_ctrl`=0.
  - n=55 → `halt_ctrl`=1, `tm64_ctrl`=23.
  - n=59 → `halt_ctrl`=1, `tm64_ctrl`=27.
  - `dout_sop` appears 4 cycles after the input sop (TM_LATENCY=3).
- STAGE=1, n=27 → `halt_ctrl`=1, `tm64_ctrl`=22. STAGE=5: odd n → `halt_ctrl`=1, `tm64_ctrl`=0; even n → `halt_ctrl`=0.
- Valid gaps of 1–3 cycles inserted randomly mid-frame → control outputs hold during gaps; index sequence identical to the gap-free run; exactly 64 `dout_valid` pulses.
- Valid without sop from IDLE → `frame_err` pulse one cycle later; no `dout_valid`. Early sop at n=40 → `frame_err` pulse; next sample restarts at n=0 (STAGE=0 gives `halt_ctrl`=0).
- `rst_n` low for 2 cycles at n=30 with markers in flight → all outputs 0 during reset; no stale `dout_valid` after release; next frame starts cleanly.
- With `FFT_TM_CTRL_IFFT_EN` defined, `inverse`=1, STAGE=0, n=59 → `tm64_ctrl`=37; at n=32 → `tm64_ctrl`=0.
